// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter for a one-hot-select register file, with registered En/Cs/In.
// Define REGFILE_ARB_CLEAR_EN to compile in the full-file clear sweep.
module regfile_write_arbiter #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 3,
   parameter int REQS   = 2,
   parameter int AW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [REQS-1:0]         i_req,
   input  logic [REQS*AW-1:0]      i_addr,
   input  logic [REQS*WIDTH-1:0]   i_data,
   output logic [REQS-1:0]         o_ack,
   output logic                    o_err,
   input  logic                    i_clear,
   output logic                    o_busy,
   output logic                    o_rf_en,
   output logic [HEIGHT-1:0]       o_rf_cs,
   output logic [WIDTH-1:0]        o_rf_in
);

   localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;
   localparam logic [HEIGHT-1:0] HeightOne = HEIGHT'(1);
   localparam logic [REQS-1:0]   ReqOne    = REQS'(1);

`ifdef REGFILE_ARB_CLEAR_EN
   typedef enum logic [1:0] {StIdle, StWrite, StClear} state_t;
`else
   typedef enum logic [1:0] {StIdle, StWrite} state_t;
`endif

   state_t              r_state;
   logic [PW-1:0]       r_ptr;
   logic                r_rf_en;
   logic [HEIGHT-1:0]   r_rf_cs;
   logic [WIDTH-1:0]    r_rf_in;
   logic [REQS-1:0]     r_ack;
   logic                r_err;

`ifdef REGFILE_ARB_CLEAR_EN
   logic                r_pend;
   logic [AW-1:0]       r_row;
`else
   logic                w_unused_clear;
   assign w_unused_clear = i_clear;
`endif

   logic                w_any;
   logic [PW-1:0]       w_gnt;
   logic [PW-1:0]       w_ptr_nxt;
   logic [AW-1:0]       w_addr;
   logic [WIDTH-1:0]    w_data;
   logic                w_in_range;
   logic [REQS-1:0]     w_gnt_oh;

   // First requester at or after r_ptr, wrapping modulo REQS.
   always_comb begin
      int idx;
      logic [PW-1:0] idx_pw;
      w_any  = 1'b0;
      w_gnt  = '0;
      idx    = 0;
      idx_pw = '0;
      for (int k = 0; k < REQS; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= REQS) begin
            idx = idx - REQS;
         end
         idx_pw = PW'(idx);
         if (!w_any && i_req[idx_pw]) begin
            w_any = 1'b1;
            w_gnt = idx_pw;
         end
      end
   end

   assign w_addr     = i_addr[w_gnt*AW +: AW];
   assign w_data     = i_data[w_gnt*WIDTH +: WIDTH];
   assign w_in_range = (32'(w_addr) < 32'(HEIGHT));
   assign w_gnt_oh   = ReqOne << w_gnt;
   assign w_ptr_nxt  = (w_gnt == PW'(REQS - 1)) ? '0 : w_gnt + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_rf_en <= 1'b0;
         r_rf_cs <= '0;
         r_rf_in <= '0;
         r_ack   <= '0;
         r_err   <= 1'b0;
`ifdef REGFILE_ARB_CLEAR_EN
         r_pend  <= 1'b0;
         r_row   <= '0;
`endif
      end else begin
         r_rf_en <= 1'b0;
         r_rf_cs <= '0;
         r_rf_in <= '0;
         r_ack   <= '0;
         r_err   <= 1'b0;
`ifdef REGFILE_ARB_CLEAR_EN
         if (i_clear) begin
            r_pend <= 1'b1;
         end
`endif
         case (r_state)
            StIdle: begin
`ifdef REGFILE_ARB_CLEAR_EN
               // A clear sampled this cycle wins over any pending request.
               if (r_pend || i_clear) begin
                  r_state <= StClear;
                  r_row   <= '0;
                  r_rf_en <= 1'b1;
                  r_rf_cs <= HeightOne;
               end else
`endif
               if (w_any) begin
                  r_state <= StWrite;
                  r_ack   <= w_gnt_oh;
                  r_ptr   <= w_ptr_nxt;
                  if (w_in_range) begin
                     r_rf_en <= 1'b1;
                     r_rf_cs <= HeightOne << w_addr;
                     r_rf_in <= w_data;
                  end else begin
                     r_err   <= 1'b1;
                  end
               end
            end
            StWrite: begin
               r_state <= StIdle;
            end
`ifdef REGFILE_ARB_CLEAR_EN
            StClear: begin
               // Pulses seen during the sweep collapse into it.
               if (r_row == AW'(HEIGHT - 1)) begin
                  r_state <= StIdle;
                  r_pend  <= 1'b0;
                  r_row   <= '0;
               end else begin
                  r_row   <= r_row + 1'b1;
                  r_rf_en <= 1'b1;
                  r_rf_cs <= HeightOne << (r_row + 1'b1);
               end
            end
`endif
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_ack   = r_ack;
   assign o_err   = r_err;
   assign o_rf_en = r_rf_en;
   assign o_rf_cs = r_rf_cs;
   assign o_rf_in = r_rf_in;
`ifdef REGFILE_ARB_CLEAR_EN
   assign o_busy  = (r_state != StIdle) | r_pend;
`else
   assign o_busy  = (r_state != StIdle);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (WIDTH=8, HEIGHT=3, REQS=2).
// Clear-sweep scenarios run when REGFILE_ARB_CLEAR_EN is defined; otherwise Clear must be ignored.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [3:0]  addr;
   logic [15:0] data;
   logic [1:0]  ack;
   logic        err;
   logic        clear;
   logic        busy;
   logic        rf_en;
   logic [2:0]  rf_cs;
   logic [7:0]  rf_in;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(
      .WIDTH  (8),
      .HEIGHT (3),
      .REQS   (2)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_addr  (addr),
      .i_data  (data),
      .o_ack   (ack),
      .o_err   (err),
      .i_clear (clear),
      .o_busy  (busy),
      .o_rf_en (rf_en),
      .o_rf_cs (rf_cs),
      .o_rf_in (rf_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic [2:0] cs,
                          input logic [7:0] din, input logic [1:0] a, input logic e,
                          input logic b);
      chk({tag, ".en"},   32'(rf_en), 32'(en));
      chk({tag, ".cs"},   32'(rf_cs), 32'(cs));
      chk({tag, ".in"},   32'(rf_in), 32'(din));
      chk({tag, ".ack"},  32'(ack),   32'(a));
      chk({tag, ".err"},  32'(err),   32'(e));
      chk({tag, ".busy"}, 32'(busy),  32'(b));
   endtask

   initial begin
      rst   = 1'b1;
      req   = 2'b00;
      addr  = 4'h0;
      data  = 16'h0000;
      clear = 1'b0;
      step();
      step();
      chk_out("reset", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_out("idle0", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);

      // Single requester 0 writes row 2.
      req  = 2'b01;
      addr = {2'd0, 2'd2};
      data = {8'h00, 8'hA5};
      step();
      chk_out("single", 1'b1, 3'b100, 8'hA5, 2'b01, 1'b0, 1'b1);
      req = 2'b00;
      step();
      chk_out("single_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);

      // Reset to bring Ptr back to 0, then contend with both requesters.
      rst = 1'b1;
      step();
      rst  = 1'b0;
      req  = 2'b11;
      addr = {2'd1, 2'd0};
      data = {8'h22, 8'h11};
      step();
      chk_out("rr0", 1'b1, 3'b001, 8'h11, 2'b01, 1'b0, 1'b1);
      step();
      chk_out("rr0_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      step();
      chk_out("rr1", 1'b1, 3'b010, 8'h22, 2'b10, 1'b0, 1'b1);
      step();
      chk("rr1_idle.ack", 32'(ack), 32'h0);
      step();
      chk_out("rr2", 1'b1, 3'b001, 8'h11, 2'b01, 1'b0, 1'b1);
      req = 2'b00;
      step();
      chk_out("rr2_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);

      // Out-of-range address: Ptr=1, only requester 0 asks.
      req  = 2'b01;
      addr = {2'd0, 2'd3};
      data = {8'h00, 8'hFF};
      step();
      chk("oor.ack",  32'(ack),   32'h1);
      chk("oor.err",  32'(err),   32'h1);
      chk("oor.en",   32'(rf_en), 32'h0);
      chk("oor.cs",   32'(rf_cs), 32'h0);
      req = 2'b00;
      step();
      chk_out("oor_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);

`ifdef REGFILE_ARB_CLEAR_EN
      // Clear in IDLE with Req[1] high: sweep first, then the write.
      clear = 1'b1;
      req   = 2'b10;
      addr  = {2'd1, 2'd0};
      data  = {8'h5A, 8'h00};
      step();
      clear = 1'b0;
      chk_out("clr_r0", 1'b1, 3'b001, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("clr_r1", 1'b1, 3'b010, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("clr_r2", 1'b1, 3'b100, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("clr_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      step();
      chk_out("clr_wr", 1'b1, 3'b010, 8'h5A, 2'b10, 1'b0, 1'b1);
      req = 2'b00;
      step();
      chk_out("clr_wr_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);

      // Clear during the Ack cycle, plus a second pulse: one sweep only.
      req  = 2'b01;
      addr = {2'd0, 2'd0};
      data = {8'h00, 8'h33};
      step();
      chk_out("cw_wr", 1'b1, 3'b001, 8'h33, 2'b01, 1'b0, 1'b1);
      req   = 2'b00;
      clear = 1'b1;
      step();
      chk_out("cw_pend", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      clear = 1'b0;
      chk_out("cw_r0", 1'b1, 3'b001, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("cw_r1", 1'b1, 3'b010, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("cw_r2", 1'b1, 3'b100, 8'h00, 2'b00, 1'b0, 1'b1);
      step();
      chk_out("cw_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      step();
      chk_out("cw_once", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);

      // Reset after row 0 of a sweep aborts it.
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk_out("rc_r0", 1'b1, 3'b001, 8'h00, 2'b00, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      chk_out("rc_rst", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_out("rc_after0", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      step();
      chk_out("rc_after1", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
`else
      // Clear is ignored: no busy, and a coincident request is served directly.
      clear = 1'b1;
      step();
      chk_out("noclr_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
      req  = 2'b01;
      addr = {2'd0, 2'd1};
      data = {8'h00, 8'hC3};
      step();
      clear = 1'b0;
      chk_out("noclr_wr", 1'b1, 3'b010, 8'hC3, 2'b01, 1'b0, 1'b1);
      req = 2'b00;
      step();
      chk_out("noclr_wr_idle", 1'b0, 3'b000, 8'h00, 2'b00, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-side controller for the flat-output register file (HEIGHT rows × WIDTH bits, one-hot row select, shared enable and data bus). It arbitrates round-robin between REQS independent writers and drives the file's En/Cs/In with registered outputs. It returns a one-cycle Ack per accepted request. Optionally it sequences a full-file clear sweep.

## Interface
- WIDTH, 8, row width in bits
- HEIGHT, 3, number of register rows
- REQS, 2, number of write requesters (≥1)
- AW, $clog2(HEIGHT) (min 1), row address width (derived)

- Clk  in  1  system clock, all activity on rising edge
- Rst  in  1  synchronous, active-high reset
- Req  in  REQS  per-requester write request, level
- Addr  in  REQS*AW  flat row addresses, requester i at [AW*(i+1)-1:AW*i]
- Data  in  REQS*WIDTH  flat write data, requester i at [WIDTH*(i+1)-1:WIDTH*i]
- Ack  out  REQS  one-cycle completion pulse to the granted requester
- Err  out  1  pulses with Ack when the granted Addr ≥ HEIGHT
- Clear  in  1  pulse: request zeroing of all rows (CLEAR feature only)
- Busy  out  1  high whenever state ≠ IDLE or a clear is pending
- RfEn  out  1  to register file En
- RfCs  out  HEIGHT  to register file Cs, one-hot or zero
- RfIn  out  WIDTH  to register file In

## Operation
- States: IDLE, WRITE, CLEAR (CLEAR exists only with the macro).
- IDLE, clear pending: go to CLEAR with row counter 0. Clear takes priority over Req.
- IDLE, any Req bit high, no clear pending:
  - Grant the first requester at or after the rotating pointer Ptr, searching upward modulo REQS.
  - Latch the granted requester's Addr and Data, then go to WRITE.
- WRITE (one cycle):
  - Addr < HEIGHT: RfEn=1, RfCs=one-hot(Addr), RfIn=Data, Ack[g]=1.
  - Addr ≥ HEIGHT: RfEn=0, RfCs=0, Ack[g]=1, Err=1.
  - Ptr ← (g+1) mod REQS. Next state is always IDLE.
- CLEAR:
  - Each cycle: RfEn=1, RfCs=one-hot(row), RfIn=0, then row++.
  - After row HEIGHT-1, return to IDLE and drop the pending flag.
  - Ack is never asserted during CLEAR.
- Clear arriving outside IDLE sets the pending flag, served on the next IDLE cycle. Multiple pulses collapse into one.
- Requester rules:
  - Hold Req, Addr and Data stable until Ack.
  - Deassert Req at the edge ending the Ack cycle, or hold it to request another write.
  - A Req dropped before Ack is protocol violation. Behaviour is undefined, but no X on outputs.
- Outside WRITE and CLEAR: RfEn=0, RfCs=0, RfIn=0, Ack=0, Err=0.

## Timing
- Reset (Rst high at an edge):
  - State=IDLE, Ptr=0, pending=0, row=0.
  - Outputs: RfEn=0, RfCs=0, RfIn=0, Ack=0, Err=0, Busy=0.
- Reset mid-WRITE or mid-CLEAR aborts immediately. Rows already written keep their values.
- All outputs are registered, driven from state; no combinational path from Req to Ack.
- Latency: Req sampled high in IDLE at edge N → RfEn and Ack high in cycle N+1 → write lands in the file at edge N+2.
- Throughput: one write per 2 cycles. A clear takes HEIGHT cycles plus one IDLE cycle of entry latency.
- Simultaneous Req and Clear in IDLE: clear wins. Requests wait and remain granted in round-robin order afterwards.
- RfCs is never multi-hot.

## Configuration
- REGFILE_ARB_CLEAR_EN defined:
  - CLEAR state, row counter and pending flag are compiled in.
  - Clear behaves as described above.
- REGFILE_ARB_CLEAR_EN undefined:
  - Clear port remains but is ignored; no CLEAR state.
  - Busy = (state ≠ IDLE).

## Test plan
- After reset, single requester: Req[0]=1, Addr=2, Data=0xA5 → cycle N+1 shows RfEn=1, RfCs=3'b100, RfIn=0xA5, Ack=2'b01, Err=0.
- Contention: Req=2'b11 held continuously with Ptr=0 → Acks alternate 01, 10, 01 on every second cycle.
- Out of range: HEIGHT=3, Addr=3 → Ack pulses, Err=1, RfEn=0, RfCs=0.
- Clear (macro on): Clear pulse in IDLE with Req[1] high → RfCs steps 001, 010, 100 with RfIn=0, Busy=1, no Ack. Then Ack[1] arrives in the cycle after the returning IDLE.
- Clear during WRITE: Clear pulse coincident with the Ack cycle → sweep starts after the next IDLE. Two pulses produce a single sweep.
- Reset mid-CLEAR after row 0: Rst pulse → all outputs 0, state IDLE, no further RfEn.
